// File: rtl/mips_defs_pkg.sv
// mips_defs: shared definitions for the multiply/divide unit.
//   - funct codes of the HI/LO and mult/div R-type instructions
//   - MDU controller state encoding
//   - default operand width
// No ports; imported by mdu_shift_core and mdu_sequencer.
package mips_defs;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;

    // MULT/MULTU/DIV/DIVU share the prefix 0110.
    function automatic logic is_muldiv(input logic [5:0] fn);
        return fn[5:2] == 4'b0110;
    endfunction

    // MFHI/MTHI/MFLO/MTLO share the prefix 0100.
    function automatic logic is_hilo_move(input logic [5:0] fn);
        return fn[5:2] == 4'b0100;
    endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// mdu_shift_core: combinational single-iteration datapath of the MDU.
// Ports:
//   i_is_div   - 1: restoring-division step, 0: shift-add multiply step
//   i_acc      - 2*WIDTH accumulator {upper, lower}
//   i_opnd     - multiplicand (mul) or divisor (div) magnitude
//   o_acc      - accumulator after one iteration
//   o_neg_prod - two's-complement negation of the full accumulator
//   o_neg_hi   - negation of the upper half
//   o_neg_lo   - negation of the lower half
module mdu_shift_core
    import mips_defs::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic [2*WIDTH-1:0]   o_neg_prod,
    output logic [WIDTH-1:0]     o_neg_hi,
    output logic [WIDTH-1:0]     o_neg_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_sub;
    logic             w_fits;

    always_comb begin
        // Multiply: {upper, lower} holds {partial product, remaining multiplier};
        // add the multiplicand when the multiplier lsb is set, then shift right
        // with the carry dropping into the top bit.
        w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);

        // Divide: {upper, lower} holds {partial remainder, remaining dividend};
        // shift left one bit, then subtract the divisor if it fits.
        w_trial   = i_acc[2*WIDTH-1:WIDTH-1];
        w_fits    = (w_trial >= {1'b0, i_opnd});
        // The difference is below the divisor, so WIDTH bits are enough.
        w_rem_sub = w_trial[WIDTH-1:0] - i_opnd;

        if (i_is_div) begin
            if (w_fits) begin
                o_acc = {w_rem_sub, i_acc[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

    assign o_neg_prod = '0 - i_acc;
    assign o_neg_hi   = '0 - i_acc[2*WIDTH-1:WIDTH];
    assign o_neg_lo   = '0 - i_acc[WIDTH-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative multiply/divide controller owning HI/LO.
// Executes MULT/MULTU/DIV/DIVU one bit per cycle (RUN), applies sign
// correction in FIXUP, serves MFHI/MFLO/MTHI/MTLO and stalls dependent
// HI/LO instructions while an operation is in flight.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   ex_valid, Function - R-type instruction in EX and its funct field
//   rs_data, rt_data   - operands A and B (MTHI/MTLO source is rs_data)
//   flush              - squash any in-flight operation
//   stall              - hold IF/ID/EX
//   busy               - operation in flight (RUN or FIXUP)
//   done, div_by_zero  - one-cycle completion pulses
//   hi, lo             - HI/LO registers
//   mf_data            - MFHI/MFLO read data, 0 for other functs
module mdu_sequencer
    import mips_defs::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic [5:0]       Function,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_is_div;
    logic               r_neg_res;   // product/quotient must be negated
    logic               r_neg_rem;   // remainder takes the dividend's sign
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dz_pulse;

    logic [1:0]         w_state_next;
    logic [CW-1:0]      w_cnt_next;
    logic               w_accept;
    logic               w_signed;
    logic               w_is_div;
    logic               w_sa;
    logic               w_sb;
    logic               w_dz;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_fixup_done;
    logic               w_mt_ok;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;
    logic [2*WIDTH-1:0] w_core_acc;
    logic [2*WIDTH-1:0] w_neg_prod;
    logic [WIDTH-1:0]   w_neg_hi;
    logic [WIDTH-1:0]   w_neg_lo;

    mdu_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_is_div   (r_is_div),
        .i_acc      (r_acc),
        .i_opnd     (r_opnd),
        .o_acc      (w_core_acc),
        .o_neg_prod (w_neg_prod),
        .o_neg_hi   (w_neg_hi),
        .o_neg_lo   (w_neg_lo)
    );

    // Operand decode at accept.
    always_comb begin
        w_signed = ~Function[0];
        w_is_div = Function[1];
        w_sa     = w_signed & rs_data[WIDTH-1];
        w_sb     = w_signed & rt_data[WIDTH-1];
        w_mag_a  = w_sa ? ('0 - rs_data) : rs_data;
        w_mag_b  = w_sb ? ('0 - rt_data) : rt_data;
        w_dz     = w_is_div & (rt_data == '0);
        w_accept = (r_state == ST_IDLE) & ex_valid & ~flush & is_muldiv(Function);
        w_mt_ok  = (r_state == ST_IDLE) & ex_valid & ~flush;
        w_fixup_done = (r_state == ST_FIXUP) & ~flush;
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_next   = '0;
                    // A zero divisor has a fixed result; skip the iterations.
                    w_state_next = w_dz ? ST_FIXUP : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = ST_FIXUP;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            ST_FIXUP: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end
    end

    // Sign correction applied as the result is written to HI/LO.
    always_comb begin
        if (r_dz) begin
            w_res_hi = r_acc[WIDTH-1:0];
            w_res_lo = '1;
        end else if (r_is_div) begin
            w_res_hi = r_neg_rem ? w_neg_hi : r_acc[2*WIDTH-1:WIDTH];
            w_res_lo = r_neg_res ? w_neg_lo : r_acc[WIDTH-1:0];
        end else begin
            {w_res_hi, w_res_lo} = r_neg_res ? w_neg_prod : r_acc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dz_pulse <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_done     <= w_fixup_done;
            r_dz_pulse <= w_fixup_done & r_dz;

            if (w_accept) begin
                r_is_div  <= w_is_div;
                r_neg_res <= w_sa ^ w_sb;
                r_neg_rem <= w_sa;
                r_dz      <= w_dz;
                r_opnd    <= w_is_div ? w_mag_b : w_mag_a;
                // Lower half seeds the dividend/multiplier; on divide-by-zero it
                // carries the raw rs_data through to HI.
                r_acc     <= {{WIDTH{1'b0}},
                              (w_dz ? rs_data : (w_is_div ? w_mag_a : w_mag_b))};
            end else if (r_state == ST_RUN) begin
                r_acc <= w_core_acc;
            end

            if (w_fixup_done) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_mt_ok && Function == FN_MTHI) begin
                r_hi <= rs_data;
            end else if (w_mt_ok && Function == FN_MTLO) begin
                r_lo <= rs_data;
            end
        end
    end

    always_comb begin
        busy  = (r_state != ST_IDLE);
        stall = ex_valid & busy & (is_muldiv(Function) | is_hilo_move(Function));
        if (Function == FN_MFHI) begin
            mf_data = r_hi;
        end else if (Function == FN_MFLO) begin
            mf_data = r_lo;
        end else begin
            mf_data = '0;
        end
    end

    assign done        = r_done;
    assign div_by_zero = r_dz_pulse;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid;
    logic [5:0]  Function;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_sequencer #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ex_valid    (ex_valid),
        .Function    (Function),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo),
        .mf_data     (mf_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic exp_t ref_op(input logic [5:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
        exp_t e;
        longint sp;
        longint unsigned up;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        if ((f == F_DIV || f == F_DIVU) && b == 32'd0) begin
            e.dz = 1'b1;
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
        end else if (f == F_MULT) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            e.hi = sp[63:32];
            e.lo = sp[31:0];
        end else if (f == F_MULTU) begin
            up = {32'd0, a} * {32'd0, b};
            e.hi = up[63:32];
            e.lo = up[31:0];
        end else if (f == F_DIV) begin
            sp = longint'($signed(a)) / longint'($signed(b));
            e.lo = sp[31:0];
            sp = longint'($signed(a)) % longint'($signed(b));
            e.hi = sp[31:0];
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Scoreboard monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_hi", {32'd0, hi}, {32'd0, e.hi});
                    check("sb_lo", {32'd0, lo}, {32'd0, e.lo});
                    check("sb_dz", {63'd0, div_by_zero}, {63'd0, e.dz});
                end
            end else if (div_by_zero === 1'b1) begin
                check("dz_without_done", {63'd0, div_by_zero}, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in EX, hold it while stalled, retire it.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        exp_t e;
        Function = f;
        rs_data  = a;
        rt_data  = b;
        ex_valid = 1'b1;
        #1;
        cyc = 0;
        while (stall && cyc < 200) begin
            step();
            cyc++;
        end
        if (cyc >= 200) check("issue_stall_timeout", 64'd1, 64'd0);
        if (f == F_MFHI) check("mfhi_data", {32'd0, mf_data}, {32'd0, m_hi});
        if (f == F_MFLO) check("mflo_data", {32'd0, mf_data}, {32'd0, m_lo});
        if (f[5:2] == 4'b0110) begin
            e = ref_op(f, a, b);
            sb_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end
        if (f == F_MTHI) m_hi = a;
        if (f == F_MTLO) m_lo = a;
        step();
        ex_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        cyc = 0;
        while (!done && cyc < 100) begin
            step();
            cyc++;
        end
        if (cyc >= 100) check(name, 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        int unsigned k;
        logic [31:0] v;
        k = $urandom_range(0, 9);
        case (k)
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int scnt;
        int dcnt;
        exp_t e;
        logic [5:0] fsel [4];
        fsel[0] = F_MULT;
        fsel[1] = F_MULTU;
        fsel[2] = F_DIV;
        fsel[3] = F_DIVU;

        reset_n  = 1'b0;
        ex_valid = 1'b0;
        Function = F_MFHI;
        rs_data  = '0;
        rt_data  = '0;
        flush    = 1'b0;
        #3;
        check("rst_hi",   {32'd0, hi}, 64'd0);
        check("rst_lo",   {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_dz",   {63'd0, div_by_zero}, 64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();

        // MULTU max x max: done at T+34.
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cyc = 1;
        while (!done && cyc < 100) begin
            step();
            cyc++;
        end
        check("multu_latency", 64'(cyc), 64'd34);
        check("multu_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        check("multu_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
        step();

        issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg_timeout");
        check("mult_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        check("mult_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
        step();

        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg_timeout");
        check("div_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        check("div_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        step();

        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf_timeout");
        check("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        check("div_ovf_hi", {32'd0, hi}, 64'd0);
        step();

        // DIVU 5/0: busy only in T+1, results in T+2.
        issue(F_DIVU, 32'd5, 32'd0);
        check("dz_busy_t1", {63'd0, busy}, 64'd1);
        check("dz_done_t1", {63'd0, done}, 64'd0);
        step();
        check("dz_done_t2", {63'd0, done}, 64'd1);
        check("dz_flag_t2", {63'd0, div_by_zero}, 64'd1);
        check("dz_hi",      {32'd0, hi}, 64'd5);
        check("dz_lo",      {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
        check("dz_busy_t2", {63'd0, busy}, 64'd0);
        step();

        // MULT 6x7 then MFLO held in EX.
        issue(F_MULT, 32'd6, 32'd7);
        Function = F_MFLO;
        ex_valid = 1'b1;
        #1;
        cyc  = 1;
        scnt = 0;
        while (stall && cyc < 100) begin
            scnt++;
            step();
            cyc++;
        end
        check("mflo_stall_cycles", 64'(scnt), 64'd33);
        check("mflo_release_cycle", 64'(cyc), 64'd34);
        check("mflo_after_run", {32'd0, mf_data}, 64'd42);
        step();
        ex_valid = 1'b0;

        // An unrelated instruction in EX during a run never stalls.
        issue(F_MULTU, $urandom, $urandom);
        Function = F_ADD;
        ex_valid = 1'b1;
        scnt = 0;
        cyc  = 0;
        while (!done && cyc < 100) begin
            #1;
            if (stall) scnt++;
            step();
            cyc++;
        end
        check("add_never_stalls", 64'(scnt), 64'd0);
        check("add_run_finished", {63'd0, done}, 64'd1);
        ex_valid = 1'b0;
        step();

        // MTHI in IDLE.
        issue(F_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_hi", {32'd0, hi}, 64'h0000_1234);

        // MTLO issued during a run stalls, then overwrites the result.
        issue(F_MULT, 32'd1000, 32'hFFFF_FFF0);
        e = ref_op(F_MULT, 32'd1000, 32'hFFFF_FFF0);
        Function = F_MTLO;
        rs_data  = 32'hCAFE_0001;
        ex_valid = 1'b1;
        #1;
        cyc = 1;
        while (stall && cyc < 100) begin
            step();
            cyc++;
        end
        check("mtlo_release_cycle", 64'(cyc), 64'd34);
        check("mtlo_sees_result", {32'd0, lo}, {32'd0, e.lo});
        step();
        ex_valid = 1'b0;
        check("mtlo_written", {32'd0, lo}, 64'h0000_0000_CAFE_0001);
        m_lo = 32'hCAFE_0001;
        step();

        // Flush a DIV at counter 10 (cycle T+11).
        Function = F_DIV;
        rs_data  = 32'd123456;
        rt_data  = 32'd7;
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        repeat (10) step();
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy_after", {63'd0, busy}, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            step();
        end
        check("flush_no_done", 64'(dcnt), 64'd0);
        check("flush_hi_kept", {32'd0, hi}, {32'd0, m_hi});
        check("flush_lo_kept", {32'd0, lo}, {32'd0, m_lo});

        // Flush in the accept cycle suppresses the operation.
        Function = F_MULTU;
        rs_data  = 32'd3;
        rt_data  = 32'd3;
        ex_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        ex_valid = 1'b0;
        check("flush_accept_busy", {63'd0, busy}, 64'd0);
        step();

        // Reset mid-run.
        Function = F_DIVU;
        rs_data  = 32'hFFFF_0000;
        rt_data  = 32'd3;
        ex_valid = 1'b1;
        step();
        ex_valid = 1'b0;
        Function = F_MFHI;
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        check("rstrun_busy", {63'd0, busy}, 64'd0);
        check("rstrun_done", {63'd0, done}, 64'd0);
        check("rstrun_hi",   {32'd0, hi}, 64'd0);
        check("rstrun_lo",   {32'd0, lo}, 64'd0);
        check("rstrun_mf",   {32'd0, mf_data}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        step();
        reset_n = 1'b1;
        step();

        // Randomized mix, issued back-to-back so later ops stall behind earlier ones.
        for (int n = 0; n < 60; n++) begin
            int unsigned k;
            logic [31:0] a;
            logic [31:0] b;
            k = $urandom_range(0, 9);
            a = pick_operand();
            b = pick_operand();
            if (k <= 5)      issue(fsel[$urandom_range(0, 3)], a, b);
            else if (k == 6) issue(F_MFHI, a, b);
            else if (k == 7) issue(F_MFLO, a, b);
            else if (k == 8) issue(($urandom_range(0, 1) == 0) ? F_MTHI : F_MTLO, a, b);
            else             issue(F_ADD, a, b);
        end
        cyc = 0;
        while (busy && cyc < 100) begin
            step();
            cyc++;
        end
        repeat (3) step();
        check("final_hi", {32'd0, hi}, {32'd0, m_hi});
        check("final_lo", {32'd0, lo}, {32'd0, m_lo});
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
